// File: rtl/input_conditioner.sv
// Board button/switch front end: per-pin 2-flop synchroniser, independent debounce,
// one-cycle press pulses for the three buttons and debounced levels for the two switches.

module debounce_chan #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter bit IS_BTN          = 1'b0
) (
    input  logic clk,
    input  logic sync_reset,
    input  logic raw,
    output logic q
);
    // Buttons are active-low on the pin, so their idle (released) pin level is 1.
    localparam logic IDLE = IS_BTN;

    logic             s1;
    logic             s;
    logic             st;
    logic             lvl;
    logic             done;
    logic [CNT_W-1:0] cnt;

    // lvl and st share polarity: 1 means pressed / switch on.
    assign lvl  = s ^ IDLE;
    assign done = (lvl != st) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            s1  <= IDLE;
            s   <= IDLE;
            st  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s  <= s1;
            if (lvl == st) begin
                cnt <= '0;
            end else if (done) begin
                st  <= ~st;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    generate
        if (IS_BTN) begin : g_pulse
            logic re;
            // Fires on the same edge st goes 0->1, so it is high for the following cycle.
            always_ff @(posedge clk) begin
                if (sync_reset) re <= 1'b0;
                else            re <= done & ~st;
            end
            assign q = re;
        end else begin : g_level
            assign q = st;
        end
    endgenerate
endmodule

module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic [2:0] btn_n,
    input  logic [1:0] sw,
    output logic       next_led_re,
    output logic       change_mode_re,
    output logic       btn_cylic_re,
    output logic       sw_l_deb,
    output logic       sw_h_deb
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int NUM_CH = 5;

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] q;

    // Channels 0-2 are buttons, 3-4 are switches.
    assign raw = {sw, btn_n};

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_chan
            debounce_chan #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W),
                .IS_BTN         (i < 3)
            ) u_chan (
                .clk       (clk),
                .sync_reset(sync_reset),
                .raw       (raw[i]),
                .q         (q[i])
            );
        end
    endgenerate

    assign next_led_re    = q[0];
    assign change_mode_re = q[1];
    assign btn_cylic_re   = q[2];
    assign sw_l_deb       = q[3];
    assign sw_h_deb       = q[4];
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4: directed scenarios plus random
// stimulus, checked against a sample-window reference model and fixed latencies.

module tb_input_conditioner;
    localparam int D    = 4;
    localparam int MAXE = 4096;

    logic       clk = 1'b0;
    logic       sync_reset = 1'b1;
    logic [2:0] btn_n = 3'b111;
    logic [1:0] sw = 2'b00;
    logic       next_led_re, change_mode_re, btn_cylic_re, sw_l_deb, sw_h_deb;
    logic [4:0] obs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk           (clk),
        .sync_reset    (sync_reset),
        .btn_n         (btn_n),
        .sw            (sw),
        .next_led_re   (next_led_re),
        .change_mode_re(change_mode_re),
        .btn_cylic_re  (btn_cylic_re),
        .sw_l_deb      (sw_l_deb),
        .sw_h_deb      (sw_h_deb)
    );

    assign obs = {sw_h_deb, sw_l_deb, btn_cylic_re, change_mode_re, next_led_re};

    // Reference model. Levels are logical (1 = pressed / on). cap[n] is what the pin
    // presented at edge n; vis[n] is what the debouncer sees at edge n (two edges later).
    // A channel's stable level flips at edge n when the D samples seen at edges
    // n-D+1..n all disagree with it and none of those edges precede the last flip/reset.
    logic [4:0] cap [MAXE];
    logic [4:0] vis [MAXE];
    bit         rst_h [MAXE];
    logic [4:0] st_m = '0;
    logic [4:0] exp_q = '0;
    int         last_flip [5];
    int         n = 0;

    task automatic model_edge(input logic [2:0] b, input logic [1:0] s, input logic r);
        bit ok;
        cap[n]   = r ? 5'b0 : {s, ~b};
        rst_h[n] = r;
        vis[n]   = (n < 2 || rst_h[n-1]) ? 5'b0 : cap[n-2];
        exp_q    = '0;
        if (r) begin
            st_m = '0;
            for (int c = 0; c < 5; c++) last_flip[c] = n;
        end else begin
            for (int c = 0; c < 5; c++) begin
                ok = (last_flip[c] <= n - D);
                for (int j = n - D + 1; j <= n; j++)
                    if (j < 0 || vis[j][c] == st_m[c]) ok = 1'b0;
                if (ok) begin
                    st_m[c]      = ~st_m[c];
                    last_flip[c] = n;
                    if (c < 3 && st_m[c]) exp_q[c] = 1'b1;
                end
            end
            exp_q[4:3] = st_m[4:3];
        end
        n++;
    endtask

    // Drive mid-cycle, take one rising edge, then sample 1 ns later.
    task automatic cyc(input logic [2:0] b, input logic [1:0] s, input logic r);
        @(negedge clk);
        btn_n = b;
        sw = s;
        sync_reset = r;
        @(posedge clk);
        model_edge(b, s, r);
        #1;
    endtask

    task automatic test_reset;
        for (int k = 1; k <= 3; k++) begin
            cyc(3'b111, 2'b00, 1'b1);
            checks++;
            if (obs !== 5'b0) begin
                errors++;
                $display("FAIL reset_hold k=%0d got=%b want=%b", k, obs, 5'b0);
            end
        end
        for (int k = 1; k <= 20; k++) begin
            cyc(3'b111, 2'b00, 1'b0);
            checks++;
            if (obs !== 5'b0) begin
                errors++;
                $display("FAIL reset_idle k=%0d got=%b want=%b", k, obs, 5'b0);
            end
        end
    endtask

    task automatic test_press;
        for (int k = 1; k <= 20; k++) begin
            cyc(3'b110, 2'b00, 1'b0);
            checks++;
            if (obs !== {4'b0, k == 6}) begin
                errors++;
                $display("FAIL press k=%0d got=%b want=%b", k, obs, {4'b0, k == 6});
            end
            checks++;
            if (obs !== exp_q) begin
                errors++;
                $display("FAIL press_model k=%0d got=%b want=%b", k, obs, exp_q);
            end
        end
        for (int k = 1; k <= 12; k++) begin
            cyc(3'b111, 2'b00, 1'b0);
            checks++;
            if (obs !== 5'b0) begin
                errors++;
                $display("FAIL release k=%0d got=%b want=%b", k, obs, 5'b0);
            end
        end
    endtask

    task automatic test_glitch;
        logic [2:0] pat [18];
        for (int k = 0; k < 18; k++) pat[k] = 3'b111;
        for (int k = 0; k < 3; k++) begin
            pat[k]     = 3'b101;
            pat[k + 5] = 3'b101;
        end
        for (int k = 0; k < 18; k++) begin
            cyc(pat[k], 2'b00, 1'b0);
            checks++;
            if (change_mode_re !== 1'b0 || obs !== exp_q) begin
                errors++;
                $display("FAIL glitch k=%0d got=%b want=%b", k, obs, 5'b0);
            end
        end
    endtask

    task automatic test_bounce;
        int pulses = 0;
        for (int p = 0; p < 8; p++)
            for (int k = 0; k < 2; k++) begin
                cyc((p % 2 == 0) ? 3'b011 : 3'b111, 2'b00, 1'b0);
                pulses += int'(btn_cylic_re);
            end
        for (int k = 1; k <= 15; k++) begin
            cyc(3'b011, 2'b00, 1'b0);
            pulses += int'(btn_cylic_re);
            checks++;
            if (btn_cylic_re !== (k == 6) || obs !== exp_q) begin
                errors++;
                $display("FAIL bounce k=%0d got=%b want=%b", k, btn_cylic_re, k == 6);
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL bounce_count got=%0d want=1", pulses);
        end
        for (int k = 0; k < 10; k++) cyc(3'b111, 2'b00, 1'b0);
    endtask

    task automatic test_switch;
        for (int k = 1; k <= 12; k++) begin
            cyc(3'b111, 2'b10, 1'b0);
            checks++;
            if (obs !== {k >= 6, 4'b0}) begin
                errors++;
                $display("FAIL sw_rise k=%0d got=%b want=%b", k, obs, {k >= 6, 4'b0});
            end
        end
        for (int k = 1; k <= 12; k++) begin
            cyc(3'b111, 2'b00, 1'b0);
            checks++;
            if (obs !== {k < 6, 4'b0}) begin
                errors++;
                $display("FAIL sw_fall k=%0d got=%b want=%b", k, obs, {k < 6, 4'b0});
            end
        end
    endtask

    task automatic test_reset_midcount;
        for (int k = 1; k <= 3; k++) begin
            cyc(3'b000, 2'b00, 1'b0);
            checks++;
            if (obs !== 5'b0) begin
                errors++;
                $display("FAIL midrst_pre k=%0d got=%b want=%b", k, obs, 5'b0);
            end
        end
        cyc(3'b000, 2'b00, 1'b1);
        checks++;
        if (obs !== 5'b0) begin
            errors++;
            $display("FAIL midrst_rst got=%b want=%b", obs, 5'b0);
        end
        for (int k = 1; k <= 12; k++) begin
            cyc(3'b000, 2'b00, 1'b0);
            checks++;
            if (obs !== {2'b0, {3{k == 6}}} || obs !== exp_q) begin
                errors++;
                $display("FAIL midrst_post k=%0d got=%b want=%b", k, obs, {2'b0, {3{k == 6}}});
            end
        end
        for (int k = 0; k < 10; k++) cyc(3'b111, 2'b00, 1'b0);
    endtask

    task automatic test_random;
        logic [2:0] b = 3'b111;
        logic [1:0] s = 2'b00;
        logic       r;
        for (int k = 0; k < 800; k++) begin
            for (int c = 0; c < 3; c++) if ($urandom_range(5) == 0) b[c] = ~b[c];
            for (int c = 0; c < 2; c++) if ($urandom_range(5) == 0) s[c] = ~s[c];
            r = ($urandom_range(79) == 0);
            cyc(b, s, r);
            checks++;
            if (obs !== exp_q) begin
                errors++;
                $display("FAIL random k=%0d got=%b want=%b", k, obs, exp_q);
            end
        end
    endtask

    initial begin
        for (int c = 0; c < 5; c++) last_flip[c] = 0;
        test_reset;
        test_press;
        test_glitch;
        test_bounce;
        test_switch;
        test_reset_midcount;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
